red_pitaya_daisy_link_init: RTL and testbench
=============================================

# red_pitaya_daisy_link_init

Bus-initiator sequencer that brings up a daisy-chain link by driving the daisy block's system-bus register map. On `start_i` it enables TX/RX, sends the training pattern, waits for RX trained, runs the PRBS self-test, reads back the error and data counters, and leaves TX on working data (pass) or zero data (fail). It sits beside the CPU bus arbiter and provides automatic link bring-up at boot without software.

## Interface
- `BASE_ADDR`, 32'h4050_0000, daisy register base.
- `ACK_TO`, 16, max cycles waited for `m_ack_i` per access.
- `POLL_GAP`, 1024, idle cycles between trained-flag polls.
- `TRAIN_POLLS`, 256, max polls before training failure.
- `TEST_LEN`, 65536, cycles the PRBS test runs before counters are read.
- `MIN_DAT`, 1000, minimum received-word count for pass.

Ports:
- `sys_clk_i`  in  1  clock; the only clock.
- `sys_rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle start pulse; ignored while busy.
- `abort_i`  in  1  one-cycle abort pulse; ignored while idle.
- `m_addr_o`  out  32  bus address.
- `m_wdata_o`  out  32  write data.
- `m_sel_o`  out  4  byte select; always 4'hF.
- `m_wen_o`  out  1  write strobe, one-cycle pulse.
- `m_ren_o`  out  1  read strobe, one-cycle pulse.
- `m_rdata_i`  in  32  read data, valid with ack.
- `m_ack_i`  in  1  access acknowledge.
- `m_err_i`  in  1  access error, valid with ack.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle pulse at sequence end.
- `pass_o`  out  1  result of last sequence; held until next start.
- `fail_code_o`  out  3  0 none, 1 train timeout, 2 test fail, 3 ack timeout, 4 bus error, 5 abort.
- `err_cnt_o`  out  32  captured test error count.
- `dat_cnt_o`  out  32  captured test data count.
- `state_o`  out  4  FSM state encoding, debug.

## Operation
- Reset: all outputs 0; FSM IDLE; counters cleared. Takes effect mid-access; strobes drop the next edge, with no cleanup write.
- Register offsets: 0x00 CTRL (b0 tx_en, b1 rx_en), 0x04 TXCFG (b[2:0] sel), 0x08 TRAIN (write b0; read b4 trained), 0x10 TSTCLR, 0x14 ERRCNT, 0x18 DATCNT. `m_addr_o` = `BASE_ADDR` + offset.
- Sequence states, in order:
  - IDLE.
  - W_CTRL: write 0x3 to CTRL.
  - W_TRN_PAT: write 0x3 to TXCFG.
  - W_TRAIN1: write 1 to TRAIN.
  - POLL_WAIT: wait `POLL_GAP` cycles.
  - R_TRAIN: read TRAIN.
    - If b4 = 1, go to W_TRAIN0.
    - Otherwise increment the poll count. If the count equals `TRAIN_POLLS`, fail with code 1; else return to POLL_WAIT.
  - W_TRAIN0: write 0 to TRAIN.
  - W_TST_PAT: write 0x5 to TXCFG.
  - W_CLR1: write 1 to TSTCLR.
  - W_CLR0: write 0 to TSTCLR.
  - TEST_WAIT: wait `TEST_LEN` cycles.
  - R_ERR: capture `err_cnt_o`.
  - R_DAT: capture `dat_cnt_o`.
  - Decide pass: err == 0 and dat >= `MIN_DAT` (unsigned 32-bit compare).
    - Pass: W_WORK writes 0x1 to TXCFG, then DONE.
    - Fail (code 2): go to CLEANUP.
- CLEANUP: write 0x0 to TXCFG, then DONE. The cleanup write's own timeout or error does not change the already latched code.
- Failure from any access state (ack timeout code 3, `m_err_i` code 4) or `abort_i` (code 5) latches the code and enters CLEANUP. Abort during an outstanding access waits for that ack or its timeout first. Abort in CLEANUP or DONE is ignored.
- DONE: `done_o` = 1 for one cycle, then IDLE. `pass_o` is set only on the pass path. `pass_o` and `fail_code_o` are cleared on the accepted start.
- `start_i` together with `abort_i` while idle: start is accepted and abort ignored.

## Timing
- The strobe asserts on the first cycle of each access state. `m_addr_o`/`m_wdata_o` are valid from that cycle and held until ack or timeout, then return to 0.
- Ack is sampled from the cycle after the strobe. An ack coinciding with the strobe is ignored.
- Ack timeout fires when `ACK_TO` cycles after the strobe pass without an ack.
- The next state is entered the cycle after ack, so a zero-wait slave with a registered ack gives 3 cycles per access.
- `busy_o` rises the cycle after the accepted `start_i` and falls with `done_o`.
- Wait counters load at state entry and count down to 0 inclusive; exit occurs exactly N cycles after entry.
- Poll count is 16-bit and saturates; it cannot wrap.

## Test plan
Bench parameters: `ACK_TO`=4, `POLL_GAP`=8, `TRAIN_POLLS`=3, `TEST_LEN`=100, `MIN_DAT`=10.
- Happy path: slave model acks 1 cycle after the strobe, trained=1 on the 2nd poll, ERRCNT=0, DATCNT=50 -> writes CTRL=3, TXCFG=3, TRAIN=1, TRAIN=0, TXCFG=5, TSTCLR=1/0, TXCFG=1 in order; `pass_o`=1, `fail_code_o`=0, `dat_cnt_o`=50, one `done_o` pulse.
- Never trained -> exactly 3 TRAIN reads spaced ≥8 cycles, then TXCFG=0 write; `fail_code_o`=1, `pass_o`=0.
- ERRCNT=7, DATCNT=50 -> code 2, `err_cnt_o`=7. Also ERRCNT=0, DATCNT=9 -> code 2. Also ERRCNT=0, DATCNT=10 -> pass.
- Slave withholds ack on the W_TRN_PAT write -> strobe held 4 cycles after the strobe, then code 3, cleanup write issued.
- `m_err_i` with ack on R_TRAIN -> code 4. Separately, `abort_i` during TEST_WAIT -> code 5 with no further test reads.
- `sys_rst_i` asserted during an outstanding R_ERR access -> next edge: all outputs 0, `state_o`=IDLE, no cleanup write. Also `start_i` while busy -> no effect on the sequence.

Source files
------------

// File: rtl/red_pitaya_daisy_link_init.sv
// red_pitaya_daisy_link_init: bus-initiator sequencer that trains and self-tests the daisy link.
// Ports:
//   sys_clk_i/sys_rst_i      clock, synchronous active-high reset
//   start_i/abort_i          one-cycle start and abort pulses
//   m_*                      system-bus master (addr, wdata, sel, wen, ren, rdata, ack, err)
//   busy_o/done_o/pass_o     sequence status and result
//   fail_code_o              0 none, 1 train timeout, 2 test fail, 3 ack timeout, 4 bus error, 5 abort
//   err_cnt_o/dat_cnt_o      captured PRBS counters
//   state_o                  FSM state, debug
module red_pitaya_daisy_link_init #(
   parameter logic [31:0] BASE_ADDR   = 32'h4050_0000,
   parameter int unsigned ACK_TO      = 16,
   parameter int unsigned POLL_GAP    = 1024,
   parameter int unsigned TRAIN_POLLS = 256,
   parameter int unsigned TEST_LEN    = 65536,
   parameter int unsigned MIN_DAT     = 1000
)(
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_sel_o,
   output logic        m_wen_o,
   output logic        m_ren_o,
   input  logic [31:0] m_rdata_i,
   input  logic        m_ack_i,
   input  logic        m_err_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [2:0]  fail_code_o,
   output logic [31:0] err_cnt_o,
   output logic [31:0] dat_cnt_o,
   output logic [3:0]  state_o
);
   typedef enum logic [3:0] {
      IDLE, W_CTRL, W_TRN_PAT, W_TRAIN1, POLL_WAIT, R_TRAIN, W_TRAIN0, W_TST_PAT,
      W_CLR1, W_CLR0, TEST_WAIT, R_ERR, R_DAT, W_WORK, CLEANUP, DONE
   } state_t;
   state_t      st, st_n, tgt;
   logic [1:0]  ph, ph_n, rsp, rsp_n;
   logic [31:0] tcnt, tcnt_n, errc, errc_n, datc, datc_n, wd;
   logic [15:0] pc, pc_n, pc_inc;
   logic [2:0]  code, code_n;
   logic [7:0]  off;
   logic        trn, trn_n, pend, pend_n, pass, pass_n, acc, rd, act, go;
   // access decode: ph 0 = strobe cycle, 1 = waiting for ack, 2 = bus idle before moving on
   always_comb begin
      acc = 1'b1;
      rd  = 1'b0;
      off = 8'h00;
      wd  = 32'd0;
      case (st)
         W_CTRL:    wd = 32'd3;
         W_TRN_PAT: begin off = 8'h04; wd = 32'd3; end
         W_TRAIN1:  begin off = 8'h08; wd = 32'd1; end
         R_TRAIN:   begin off = 8'h08; rd = 1'b1; end
         W_TRAIN0:  off = 8'h08;
         W_TST_PAT: begin off = 8'h04; wd = 32'd5; end
         W_CLR1:    begin off = 8'h10; wd = 32'd1; end
         W_CLR0:    off = 8'h10;
         R_ERR:     begin off = 8'h14; rd = 1'b1; end
         R_DAT:     begin off = 8'h18; rd = 1'b1; end
         W_WORK:    begin off = 8'h04; wd = 32'd1; end
         CLEANUP:   off = 8'h04;
         default:   acc = 1'b0;
      endcase
   end
   assign act         = acc && ph != 2'd2;
   assign m_addr_o    = act ? BASE_ADDR + {24'd0, off} : 32'd0;
   assign m_wdata_o   = act ? wd : 32'd0;
   assign m_sel_o     = 4'hF;
   assign m_wen_o     = acc && !rd && ph == 2'd0;
   assign m_ren_o     = acc && rd && ph == 2'd0;
   assign busy_o      = st != IDLE && st != DONE;
   assign done_o      = st == DONE;
   assign pass_o      = pass;
   assign fail_code_o = code;
   assign err_cnt_o   = errc;
   assign dat_cnt_o   = datc;
   assign state_o     = st;
   always_comb begin
      st_n   = st;
      ph_n   = ph;
      tcnt_n = tcnt;
      pc_n   = pc;
      rsp_n  = rsp;
      trn_n  = trn;
      pend_n = pend;
      pass_n = pass;
      code_n = code;
      errc_n = errc;
      datc_n = datc;
      go     = 1'b0;
      tgt    = state_t'(st + 4'd1);
      pc_inc = pc == 16'hFFFF ? pc : pc + 16'd1;
      // an abort during an access is remembered until that access completes
      if (acc && st != CLEANUP && abort_i) pend_n = 1'b1;
      if (st == IDLE) begin
         if (start_i) begin
            go     = 1'b1;
            tgt    = W_CTRL;
            pass_n = 1'b0;
            code_n = 3'd0;
            errc_n = 32'd0;
            datc_n = 32'd0;
            pc_n   = 16'd0;
         end
      end else if (st == DONE) begin
         go  = 1'b1;
         tgt = IDLE;
      end else if (!acc) begin
         if (abort_i) begin
            go     = 1'b1;
            tgt    = CLEANUP;
            code_n = 3'd5;
         end else if (tcnt == 32'd0) go = 1'b1;
         else tcnt_n = tcnt - 32'd1;
      end else if (ph == 2'd0) ph_n = 2'd1;
      else if (ph == 2'd1) begin
         if (m_ack_i) begin
            ph_n  = 2'd2;
            rsp_n = m_err_i ? 2'd2 : 2'd0;
            trn_n = m_rdata_i[4];
            if (!m_err_i && st == R_ERR) errc_n = m_rdata_i;
            if (!m_err_i && st == R_DAT) datc_n = m_rdata_i;
         end else if (tcnt == 32'd0) begin
            ph_n  = 2'd2;
            rsp_n = 2'd1;
         end else tcnt_n = tcnt - 32'd1;
      end else begin
         go = 1'b1;
         // CLEANUP never overwrites the code already latched
         if (st == CLEANUP) tgt = DONE;
         else if (rsp != 2'd0) begin
            tgt    = CLEANUP;
            code_n = rsp == 2'd1 ? 3'd3 : 3'd4;
         end else if (pend || abort_i) begin
            tgt    = CLEANUP;
            code_n = 3'd5;
         end else if (st == R_TRAIN) begin
            pc_n = pc_inc;
            if (trn) tgt = W_TRAIN0;
            else if ({16'd0, pc_inc} == TRAIN_POLLS) begin
               tgt    = CLEANUP;
               code_n = 3'd1;
            end else tgt = POLL_WAIT;
         end else if (st == R_DAT) begin
            if (errc == 32'd0 && datc >= MIN_DAT) tgt = W_WORK;
            else begin
               tgt    = CLEANUP;
               code_n = 3'd2;
            end
         end else if (st == W_WORK) begin
            tgt    = DONE;
            pass_n = 1'b1;
         end
      end
      // wait states count N-1..0 so they last exactly N cycles
      if (go) begin
         st_n   = tgt;
         ph_n   = 2'd0;
         pend_n = 1'b0;
         tcnt_n = tgt == POLL_WAIT ? POLL_GAP - 1 : tgt == TEST_WAIT ? TEST_LEN - 1 : ACK_TO - 1;
      end
   end
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         st   <= IDLE;
         ph   <= 2'd0;
         tcnt <= 32'd0;
         pc   <= 16'd0;
         rsp  <= 2'd0;
         trn  <= 1'b0;
         pend <= 1'b0;
         pass <= 1'b0;
         code <= 3'd0;
         errc <= 32'd0;
         datc <= 32'd0;
      end else begin
         st   <= st_n;
         ph   <= ph_n;
         tcnt <= tcnt_n;
         pc   <= pc_n;
         rsp  <= rsp_n;
         trn  <= trn_n;
         pend <= pend_n;
         pass <= pass_n;
         code <= code_n;
         errc <= errc_n;
         datc <= datc_n;
      end
   end
endmodule

// File: tb/tb_red_pitaya_daisy_link_init.sv
// tb_red_pitaya_daisy_link_init: directed self-checking bench with a registered-ack slave model.
module tb_red_pitaya_daisy_link_init;
   localparam logic [31:0] BASE = 32'h4050_0000;
   logic        sys_clk_i = 1'b0, sys_rst_i, start_i, abort_i;
   logic [31:0] m_addr_o, m_wdata_o, m_rdata_i, err_cnt_o, dat_cnt_o;
   logic [3:0]  m_sel_o, state_o;
   logic        m_wen_o, m_ren_o, m_ack_i, m_err_i, busy_o, done_o, pass_o;
   logic [2:0]  fail_code_o;
   logic        hold_trn = 1'b0, err_trn = 1'b0;
   logic [31:0] errv = 32'd0, datv = 32'd0;
   int          trn_at = 0, n_trn = 0, cyc = 0, n_done = 0, n_chk = 0, n_pass = 0;
   logic [31:0] w_off[$], w_dat[$], r_off[$];
   int          r_cyc[$];
   always #5 sys_clk_i = ~sys_clk_i;
   red_pitaya_daisy_link_init #(.BASE_ADDR(BASE), .ACK_TO(4), .POLL_GAP(8), .TRAIN_POLLS(3),
      .TEST_LEN(100), .MIN_DAT(10)) dut (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .start_i(start_i), .abort_i(abort_i),
      .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_sel_o(m_sel_o), .m_wen_o(m_wen_o),
      .m_ren_o(m_ren_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_code_o(fail_code_o),
      .err_cnt_o(err_cnt_o), .dat_cnt_o(dat_cnt_o), .state_o(state_o));
   always @(posedge sys_clk_i) cyc <= cyc + 1;
   always @(negedge sys_clk_i) if (done_o) n_done <= n_done + 1;
   // slave: logs each strobe, acks on the following cycle
   initial begin
      logic        s_stb, s_wr;
      logic [31:0] s_off, s_dat;
      m_ack_i = 1'b0;
      m_err_i = 1'b0;
      m_rdata_i = 32'd0;
      forever begin
         @(negedge sys_clk_i);
         s_stb = m_wen_o | m_ren_o;
         s_wr  = m_wen_o;
         s_off = m_addr_o - BASE;
         s_dat = m_wdata_o;
         if (m_wen_o) begin w_off.push_back(s_off); w_dat.push_back(s_dat); end
         if (m_ren_o) begin r_off.push_back(s_off); r_cyc.push_back(cyc); end
         if (m_ren_o && s_off == 32'h8) n_trn++;
         @(posedge sys_clk_i);
         #1;
         m_ack_i = s_stb && !(hold_trn && s_wr && s_off == 32'h4 && s_dat == 32'h3);
         m_err_i = m_ack_i && err_trn && !s_wr && s_off == 32'h8;
         m_rdata_i = (!m_ack_i || s_wr) ? 32'd0 : s_off == 32'h8 ? (n_trn >= trn_at ? 32'h10 : 32'h0) :
                     s_off == 32'h14 ? errv : s_off == 32'h18 ? datv : 32'd0;
      end
   end
   task automatic cfg(input int tr, input logic [31:0] e, input logic [31:0] d, input logic h, input logic ee);
      trn_at = tr == 0 ? 32'h7fff_ffff : n_trn + tr;
      errv = e;
      datv = d;
      hold_trn = h;
      err_trn = ee;
   endtask
   task automatic pulse_start(input logic ab);
      @(posedge sys_clk_i); #1 start_i = 1'b1; abort_i = ab;
      @(posedge sys_clk_i); #1 start_i = 1'b0; abort_i = 1'b0;
   endtask
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin @(negedge sys_clk_i); ok = done_o; end
      repeat (4) @(negedge sys_clk_i);
   endtask
   task automatic wait_state(input logic [3:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin @(negedge sys_clk_i); ok = state_o == s; end
   endtask
   task automatic test_reset;
      sys_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
      repeat (3) @(negedge sys_clk_i);
      n_chk++; if ({m_addr_o, m_wdata_o, m_wen_o, m_ren_o} !== 66'd0) $display("FAIL reset_bus got addr %h wdata %h wen %b ren %b exp all 0", m_addr_o, m_wdata_o, m_wen_o, m_ren_o); else n_pass++;
      n_chk++; if ({busy_o, done_o, pass_o, fail_code_o, state_o} !== 10'd0) $display("FAIL reset_status got busy %b done %b pass %b code %0d state %0d exp 0", busy_o, done_o, pass_o, fail_code_o, state_o); else n_pass++;
      n_chk++; if ({err_cnt_o, dat_cnt_o} !== 64'd0) $display("FAIL reset_cnt got err %0d dat %0d exp 0", err_cnt_o, dat_cnt_o); else n_pass++;
      @(posedge sys_clk_i); #1 sys_rst_i = 1'b0;
   endtask
   task automatic test_happy;
      logic [31:0] eo [8], ed [8];
      int w0, r0, d0, nt;
      bit ok;
      eo = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h4, 32'h10, 32'h10, 32'h4};
      ed = '{32'h3, 32'h3, 32'h1, 32'h0, 32'h5, 32'h1, 32'h0, 32'h1};
      cfg(2, 32'd0, 32'd50, 1'b0, 1'b0);
      w0 = w_off.size(); r0 = r_off.size(); d0 = n_done;
      pulse_start(1'b0);
      @(negedge sys_clk_i);
      n_chk++; if (busy_o !== 1'b1) $display("FAIL happy_busy_rise got %b exp 1", busy_o); else n_pass++;
      wait_done(ok);
      n_chk++; if (!ok) $display("FAIL happy_done got timeout exp done pulse"); else n_pass++;
      n_chk++; if (w_off.size() - w0 !== 8) $display("FAIL happy_nwrites got %0d exp 8", w_off.size() - w0); else n_pass++;
      for (int i = 0; i < 8 && w0 + i < w_off.size(); i++) begin
         n_chk++; if (w_off[w0+i] !== eo[i] || w_dat[w0+i] !== ed[i]) $display("FAIL happy_write%0d got off %h data %h exp off %h data %h", i, w_off[w0+i], w_dat[w0+i], eo[i], ed[i]); else n_pass++;
      end
      nt = 0;
      for (int i = r0; i < r_off.size(); i++) if (r_off[i] == 32'h8) nt++;
      n_chk++; if (nt !== 2) $display("FAIL happy_polls got %0d exp 2", nt); else n_pass++;
      n_chk++; if (pass_o !== 1'b1 || fail_code_o !== 3'd0) $display("FAIL happy_result got pass %b code %0d exp pass 1 code 0", pass_o, fail_code_o); else n_pass++;
      n_chk++; if (dat_cnt_o !== 32'd50) $display("FAIL happy_dat got %0d exp 50", dat_cnt_o); else n_pass++;
      n_chk++; if (n_done - d0 !== 1) $display("FAIL happy_ndone got %0d exp 1", n_done - d0); else n_pass++;
      n_chk++; if (busy_o !== 1'b0) $display("FAIL happy_busy_fall got %b exp 0", busy_o); else n_pass++;
   endtask
   task automatic test_never_trained;
      int w0, r0, c[$];
      bit ok;
      cfg(0, 32'd0, 32'd50, 1'b0, 1'b0);
      w0 = w_off.size(); r0 = r_off.size();
      pulse_start(1'b0);
      wait_done(ok);
      n_chk++; if (!ok) $display("FAIL train_done got timeout exp done pulse"); else n_pass++;
      for (int i = r0; i < r_off.size(); i++) if (r_off[i] == 32'h8) c.push_back(r_cyc[i]);
      n_chk++; if (c.size() !== 3) $display("FAIL train_polls got %0d exp 3", c.size()); else n_pass++;
      for (int i = 1; i < c.size(); i++) begin
         n_chk++; if (c[i] - c[i-1] < 8) $display("FAIL train_gap%0d got %0d exp >=8", i, c[i] - c[i-1]); else n_pass++;
      end
      n_chk++; if (w_off.size() == w0 || w_off[$] !== 32'h4 || w_dat[$] !== 32'h0) $display("FAIL train_cleanup got last write off %h data %h exp off 4 data 0", w_off[$], w_dat[$]); else n_pass++;
      n_chk++; if (fail_code_o !== 3'd1 || pass_o !== 1'b0) $display("FAIL train_result got code %0d pass %b exp code 1 pass 0", fail_code_o, pass_o); else n_pass++;
   endtask
   task automatic test_test_fail;
      logic [31:0] ev [3], dv [3];
      logic [2:0]  ec [3];
      logic        ep [3];
      bit ok;
      ev = '{32'd7, 32'd0, 32'd0};
      dv = '{32'd50, 32'd9, 32'd10};
      ec = '{3'd2, 3'd2, 3'd0};
      ep = '{1'b0, 1'b0, 1'b1};
      for (int v = 0; v < 3; v++) begin
         cfg(1, ev[v], dv[v], 1'b0, 1'b0);
         pulse_start(1'b0);
         wait_done(ok);
         n_chk++; if (!ok) $display("FAIL tst%0d_done got timeout exp done pulse", v); else n_pass++;
         n_chk++; if (fail_code_o !== ec[v] || pass_o !== ep[v]) $display("FAIL tst%0d_result got code %0d pass %b exp code %0d pass %b", v, fail_code_o, pass_o, ec[v], ep[v]); else n_pass++;
         n_chk++; if (err_cnt_o !== ev[v] || dat_cnt_o !== dv[v]) $display("FAIL tst%0d_cnt got err %0d dat %0d exp err %0d dat %0d", v, err_cnt_o, dat_cnt_o, ev[v], dv[v]); else n_pass++;
      end
   endtask
   task automatic test_ack_timeout;
      bit ok;
      cfg(1, 32'd0, 32'd50, 1'b1, 1'b0);
      pulse_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin @(negedge sys_clk_i); ok = m_wen_o && m_addr_o == BASE + 32'h4 && m_wdata_o == 32'h3; end
      n_chk++; if (!ok) $display("FAIL ato_strobe got none exp TXCFG=3 write"); else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         @(negedge sys_clk_i);
         n_chk++; if (m_addr_o !== BASE + 32'h4 || m_wen_o !== 1'b0) $display("FAIL ato_hold%0d got addr %h wen %b exp addr %h wen 0", k, m_addr_o, m_wen_o, BASE + 32'h4); else n_pass++;
      end
      @(negedge sys_clk_i);
      n_chk++; if (m_addr_o !== 32'd0) $display("FAIL ato_release got addr %h exp 0", m_addr_o); else n_pass++;
      wait_done(ok);
      n_chk++; if (!ok) $display("FAIL ato_done got timeout exp done pulse"); else n_pass++;
      n_chk++; if (fail_code_o !== 3'd3 || pass_o !== 1'b0) $display("FAIL ato_result got code %0d pass %b exp code 3 pass 0", fail_code_o, pass_o); else n_pass++;
      n_chk++; if (w_off[$] !== 32'h4 || w_dat[$] !== 32'h0) $display("FAIL ato_cleanup got last write off %h data %h exp off 4 data 0", w_off[$], w_dat[$]); else n_pass++;
   endtask
   task automatic test_bus_err;
      int w0;
      bit ok;
      cfg(1, 32'd0, 32'd50, 1'b0, 1'b1);
      w0 = w_off.size();
      pulse_start(1'b0);
      wait_done(ok);
      n_chk++; if (!ok) $display("FAIL berr_done got timeout exp done pulse"); else n_pass++;
      n_chk++; if (fail_code_o !== 3'd4) $display("FAIL berr_code got %0d exp 4", fail_code_o); else n_pass++;
      n_chk++; if (w_off.size() - w0 !== 4 || w_off[$] !== 32'h4 || w_dat[$] !== 32'h0) $display("FAIL berr_writes got %0d writes last off %h data %h exp 4 writes last off 4 data 0", w_off.size() - w0, w_off[$], w_dat[$]); else n_pass++;
   endtask
   task automatic test_abort;
      int r0, nr;
      bit ok;
      cfg(1, 32'd0, 32'd50, 1'b0, 1'b0);
      r0 = r_off.size();
      pulse_start(1'b0);
      wait_state(4'd10, ok);
      n_chk++; if (!ok) $display("FAIL abort_reach got timeout exp TEST_WAIT"); else n_pass++;
      repeat (5) @(posedge sys_clk_i);
      #1 abort_i = 1'b1;
      @(posedge sys_clk_i); #1 abort_i = 1'b0;
      wait_done(ok);
      n_chk++; if (!ok) $display("FAIL abort_done got timeout exp done pulse"); else n_pass++;
      n_chk++; if (fail_code_o !== 3'd5 || pass_o !== 1'b0) $display("FAIL abort_result got code %0d pass %b exp code 5 pass 0", fail_code_o, pass_o); else n_pass++;
      nr = 0;
      for (int i = r0; i < r_off.size(); i++) if (r_off[i] == 32'h14 || r_off[i] == 32'h18) nr++;
      n_chk++; if (nr !== 0) $display("FAIL abort_reads got %0d counter reads exp 0", nr); else n_pass++;
      n_chk++; if (w_off[$] !== 32'h4 || w_dat[$] !== 32'h0) $display("FAIL abort_cleanup got last write off %h data %h exp off 4 data 0", w_off[$], w_dat[$]); else n_pass++;
   endtask
   task automatic test_start_busy;
      int w0, d0;
      bit ok;
      cfg(2, 32'd0, 32'd50, 1'b0, 1'b0);
      w0 = w_off.size(); d0 = n_done;
      pulse_start(1'b0);
      wait_state(4'd4, ok);
      n_chk++; if (!ok) $display("FAIL sbusy_reach got timeout exp POLL_WAIT"); else n_pass++;
      pulse_start(1'b0);
      wait_done(ok);
      n_chk++; if (!ok || pass_o !== 1'b1 || fail_code_o !== 3'd0) $display("FAIL sbusy_result got done %b pass %b code %0d exp done 1 pass 1 code 0", ok, pass_o, fail_code_o); else n_pass++;
      n_chk++; if (w_off.size() - w0 !== 8 || n_done - d0 !== 1) $display("FAIL sbusy_seq got %0d writes %0d dones exp 8 writes 1 done", w_off.size() - w0, n_done - d0); else n_pass++;
   endtask
   task automatic test_start_abort_idle;
      bit ok;
      cfg(1, 32'd0, 32'd50, 1'b0, 1'b0);
      pulse_start(1'b1);
      @(negedge sys_clk_i);
      n_chk++; if (busy_o !== 1'b1) $display("FAIL sabt_busy got %b exp 1", busy_o); else n_pass++;
      wait_done(ok);
      n_chk++; if (!ok || pass_o !== 1'b1 || fail_code_o !== 3'd0) $display("FAIL sabt_result got done %b pass %b code %0d exp done 1 pass 1 code 0", ok, pass_o, fail_code_o); else n_pass++;
   endtask
   task automatic test_reset_mid;
      int w0, d0;
      bit ok;
      cfg(1, 32'd0, 32'd50, 1'b0, 1'b0);
      pulse_start(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin @(negedge sys_clk_i); ok = m_ren_o && m_addr_o == BASE + 32'h14; end
      n_chk++; if (!ok) $display("FAIL rmid_reach got timeout exp ERRCNT read"); else n_pass++;
      sys_rst_i = 1'b1;
      w0 = w_off.size(); d0 = n_done;
      @(negedge sys_clk_i);
      n_chk++; if ({m_addr_o, m_wdata_o, m_wen_o, m_ren_o} !== 66'd0) $display("FAIL rmid_bus got addr %h wdata %h wen %b ren %b exp all 0", m_addr_o, m_wdata_o, m_wen_o, m_ren_o); else n_pass++;
      n_chk++; if ({busy_o, done_o, pass_o, fail_code_o, state_o, err_cnt_o, dat_cnt_o} !== 74'd0) $display("FAIL rmid_status got busy %b done %b pass %b code %0d state %0d err %0d dat %0d exp 0", busy_o, done_o, pass_o, fail_code_o, state_o, err_cnt_o, dat_cnt_o); else n_pass++;
      @(posedge sys_clk_i); #1 sys_rst_i = 1'b0;
      repeat (20) @(negedge sys_clk_i);
      n_chk++; if (w_off.size() !== w0 || n_done !== d0 || state_o !== 4'd0) $display("FAIL rmid_quiet got %0d writes %0d dones state %0d exp 0 0 0", w_off.size() - w0, n_done - d0, state_o); else n_pass++;
   endtask
   initial begin
      test_reset;
      test_happy;
      test_never_trained;
      test_test_fail;
      test_ack_timeout;
      test_bus_err;
      test_abort;
      test_start_busy;
      test_start_abort_idle;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
